// File: rtl/vector_pkg.sv
// Shared encodings for the vector arbiter: requester op codes and controller FSM states.
package vector_pkg;

   typedef enum logic [1:0] {
      OP_GET    = 2'd0,
      OP_INSERT = 2'd1,
      OP_REMOVE = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the requester that did not win last time wins a tie.
module rr_arbiter2
   import vector_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic grant_b,
   output logic any_req
);

   logic last_grant_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= GRANT_B;
      end else if (update) begin
         last_grant_q <= grant_b;
      end
   end

   always_comb begin
      any_req = req_a | req_b;
      if (req_a && req_b) begin
         grant_b = (last_grant_q == GRANT_A);
      end else begin
         grant_b = req_b;
      end
   end

endmodule

// File: rtl/vector_arbiter.sv
// Shares one vector storage instance between requesters A and B: validates each request
// against the current length, issues a single-cycle op pulse and returns done/err/rdata.
module vector_arbiter
   import vector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 7,
   parameter int unsigned DATA_COUNT = 127,
   localparam int unsigned INDEX_WIDTH = $clog2(DATA_COUNT),
   localparam int unsigned LENGTH_WIDTH = $clog2(DATA_COUNT + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    a_req,
   input  logic [1:0]              a_op,
   input  logic [INDEX_WIDTH-1:0]  a_index,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic                    a_done,
   output logic                    a_err,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   input  logic                    b_req,
   input  logic [1:0]              b_op,
   input  logic [INDEX_WIDTH-1:0]  b_index,
   input  logic [DATA_WIDTH-1:0]   b_wdata,
   output logic                    b_done,
   output logic                    b_err,
   output logic [DATA_WIDTH-1:0]   b_rdata,
   output logic [INDEX_WIDTH-1:0]  vec_index,
   output logic                    vec_get,
   output logic                    vec_insert,
   output logic                    vec_remove,
   output logic [DATA_WIDTH-1:0]   vec_data_in,
   input  logic [DATA_WIDTH-1:0]   vec_data_out,
   input  logic [LENGTH_WIDTH-1:0] vec_length,
   input  logic                    vec_ready
);

   localparam logic [LENGTH_WIDTH-1:0] CountL = LENGTH_WIDTH'(DATA_COUNT);

   state_e                  state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [INDEX_WIDTH-1:0]  index_q, index_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    grant_q, grant_d;
   logic                    err_q, err_d;
   logic                    wait_first_q, wait_first_d;
   logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;

   logic                    grant_b, any_req, arb_update;
   logic [1:0]              sel_op;
   logic [INDEX_WIDTH-1:0]  sel_index;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [LENGTH_WIDTH-1:0] sel_index_ext;
   logic                    req_valid;

   rr_arbiter2 u_rr_arbiter2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (a_req),
      .req_b   (b_req),
      .update  (arb_update),
      .grant_b (grant_b),
      .any_req (any_req)
   );

   always_comb begin
      sel_op        = grant_b ? b_op    : a_op;
      sel_index     = grant_b ? b_index : a_index;
      sel_wdata     = grant_b ? b_wdata : a_wdata;
      sel_index_ext = LENGTH_WIDTH'(sel_index);
      unique case (sel_op)
         OP_GET:    req_valid = sel_index_ext < vec_length;
         OP_INSERT: req_valid = (vec_length < CountL) && (sel_index_ext <= vec_length);
         OP_REMOVE: req_valid = sel_index_ext < vec_length;
         default:   req_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      index_d      = index_q;
      wdata_d      = wdata_q;
      grant_d      = grant_q;
      err_d        = err_q;
      wait_first_d = wait_first_q;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;
      arb_update   = 1'b0;
      vec_get      = 1'b0;
      vec_insert   = 1'b0;
      vec_remove   = 1'b0;
      a_done       = 1'b0;
      b_done       = 1'b0;
      a_err        = 1'b0;
      b_err        = 1'b0;
      unique case (state_q)
         StIdle: begin
            // vec_ready gating also absorbs a vector op left running across a reset
            if (vec_ready && any_req) begin
               arb_update = 1'b1;
               op_d       = sel_op;
               index_d    = sel_index;
               wdata_d    = sel_wdata;
               grant_d    = grant_b;
               err_d      = ~req_valid;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            // Rejected requests pass through here without a pulse, fixing their latency at 2
            if (err_q) begin
               state_d = StResp;
            end else begin
               vec_get      = (op_q == OP_GET);
               vec_insert   = (op_q == OP_INSERT);
               vec_remove   = (op_q == OP_REMOVE);
               wait_first_d = 1'b1;
               state_d      = StWait;
            end
         end
         StWait: begin
            if (op_q == OP_GET) begin
               if (grant_q == GRANT_B) begin
                  b_rdata_d = vec_data_out;
               end else begin
                  a_rdata_d = vec_data_out;
               end
               state_d = StResp;
            end else if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (vec_ready) begin
               state_d = StResp;
            end
         end
         StResp: begin
            a_done  = (grant_q == GRANT_A);
            b_done  = (grant_q == GRANT_B);
            a_err   = (grant_q == GRANT_A) && err_q;
            b_err   = (grant_q == GRANT_B) && err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         op_q         <= '0;
         index_q      <= '0;
         wdata_q      <= '0;
         grant_q      <= GRANT_A;
         err_q        <= 1'b0;
         wait_first_q <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         index_q      <= index_d;
         wdata_q      <= wdata_d;
         grant_q      <= grant_d;
         err_q        <= err_d;
         wait_first_q <= wait_first_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   assign vec_index   = index_q;
   assign vec_data_in = wdata_q;
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;

endmodule
